// File: rtl/line_burst_reader.sv
// line_burst_reader: walks consecutive array sets, captures each line and streams it out as beats.
module line_burst_reader #(
  parameter int s_index    = 3,
  parameter int width      = 256,
  parameter int beat_width = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [s_index-1:0]    start_index,
  input  logic [s_index:0]      num_lines,
  output logic                  arr_read,
  output logic [s_index-1:0]    arr_rindex,
  input  logic [width-1:0]      arr_dataout,
  output logic [beat_width-1:0] burst_data,
  output logic                  burst_valid,
  input  logic                  burst_ready,
  output logic                  burst_last,
  output logic                  busy,
  output logic                  done
);
  localparam int beats = width / beat_width;
  localparam int bw = beats > 1 ? $clog2(beats) : 1;
  localparam logic [bw-1:0] last_beat = bw'(beats - 1);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, CAPTURE = 3'd2, SEND = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [s_index-1:0] index;
  logic [s_index:0] remaining;
  logic [bw-1:0] beat;
  logic [beats-1:0][beat_width-1:0] line_q;
  logic last;
  always_comb begin
    last = beat == last_beat;
    arr_read = state == FETCH;
    arr_rindex = index;
    burst_valid = state == SEND;
    burst_last = burst_valid && last;
    burst_data = burst_valid ? line_q[beat] : '0;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      index <= '0;
      remaining <= '0;
      beat <= '0;
      line_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          index <= start_index;
          remaining <= num_lines;
          state <= num_lines == '0 ? DONE : FETCH;
        end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          line_q <= arr_dataout;
          beat <= '0;
          state <= SEND;
        end
        SEND: if (burst_ready) begin
          if (last) begin
            remaining <= remaining - 1'b1;
            index <= index + 1'b1;
            state <= remaining == 1 ? DONE : FETCH;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_burst_reader.sv
// tb_line_burst_reader: scoreboard bench; stimulus queues expected reads/beats, a negedge monitor checks them.
module tb_line_burst_reader;
  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic [2:0] start_index = 0;
  logic [3:0] num_lines = 0;
  logic arr_read;
  logic [2:0] arr_rindex;
  logic [255:0] arr_dataout = 0;
  logic [63:0] burst_data;
  logic burst_valid;
  logic burst_ready = 1;
  logic burst_last;
  logic busy;
  logic done;

  line_burst_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_index(start_index), .num_lines(num_lines),
    .arr_read(arr_read), .arr_rindex(arr_rindex), .arr_dataout(arr_dataout),
    .burst_data(burst_data), .burst_valid(burst_valid), .burst_ready(burst_ready),
    .burst_last(burst_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [63:0] d; logic l;} beat_t;
  logic [255:0] mem [8];
  int rq[$];
  beat_t bq[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int beat_cnt = 0;

  always @(posedge clk) if (arr_read) arr_dataout <= mem[arr_rindex];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none", name);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (arr_read) begin
      rd_cnt++;
      if (rq.size() == 0) flag("unexpected_read");
      else check("rindex", 256'(arr_rindex), 256'(rq.pop_front()));
    end
    if (burst_valid && burst_ready) begin
      beat_cnt++;
      if (bq.size() == 0) flag("unexpected_beat");
      else begin
        beat_t e;
        e = bq.pop_front();
        check("beat_data", 256'(burst_data), 256'(e.d));
        check("beat_last", 256'(burst_last), 256'(e.l));
      end
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input int idx, input int n);
    for (int l = 0; l < n; l++) begin
      int i;
      i = (idx + l) % 8;
      rq.push_back(i);
      for (int k = 0; k < 4; k++) bq.push_back('{mem[i][k*64 +: 64], k == 3});
    end
  endtask

  task automatic issue(input int idx, input int n);
    expect_cmd(idx, n);
    start_index = 3'(idx);
    num_lines = 4'(n);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
    tick();
    check({name, "_idle"}, 256'(busy), 256'(0));
    check({name, "_reads_left"}, 256'(rq.size()), 256'(0));
    check({name, "_beats_left"}, 256'(bq.size()), 256'(0));
  endtask

  initial begin
    int d0, r0, b0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 4; k++)
        mem[i][k*64 +: 64] = (64'h1111_1111_1111_1111 * 64'(k + 1)) ^ {8'(i ^ 5), 56'h0};
    tick();
    tick();
    check("rst_arr_read", 256'(arr_read), 256'(0));
    check("rst_rindex", 256'(arr_rindex), 256'(0));
    check("rst_valid", 256'(burst_valid), 256'(0));
    check("rst_last", 256'(burst_last), 256'(0));
    check("rst_data", 256'(burst_data), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    rst_n = 1;
    tick();

    // basic line: cycle-accurate profile
    issue(5, 1);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("basic_read_c%0d", c), 256'(arr_read), 256'(c == 1));
      if (c == 1) check("basic_rindex", 256'(arr_rindex), 256'(5));
      check($sformatf("basic_valid_c%0d", c), 256'(burst_valid), 256'(c >= 3 && c <= 6));
      check($sformatf("basic_last_c%0d", c), 256'(burst_last), 256'(c == 6));
      check($sformatf("basic_done_c%0d", c), 256'(done), 256'(c == 7));
      check($sformatf("basic_busy_c%0d", c), 256'(busy), 256'(c <= 7));
      tick();
    end
    check("basic_beats_left", 256'(bq.size()), 256'(0));

    // backpressure on beat 2 for three cycles
    issue(5, 1);
    for (int c = 1; c <= 11; c++) begin
      burst_ready = !(c >= 5 && c <= 7);
      if (c >= 5 && c <= 7) begin
        check($sformatf("bp_hold_data_c%0d", c), 256'(burst_data), 256'(64'h3333_3333_3333_3333));
        check($sformatf("bp_hold_last_c%0d", c), 256'(burst_last), 256'(0));
      end
      check($sformatf("bp_valid_c%0d", c), 256'(burst_valid), 256'(c >= 3 && c <= 9));
      check($sformatf("bp_last_c%0d", c), 256'(burst_last), 256'(c == 9));
      check($sformatf("bp_done_c%0d", c), 256'(done), 256'(c == 10));
      tick();
    end
    burst_ready = 1;
    check("bp_beats_left", 256'(bq.size()), 256'(0));

    // wrap-around 6,7,0,1
    d0 = done_cnt; r0 = rd_cnt; b0 = beat_cnt;
    issue(6, 4);
    wait_done("wrap", 60);
    check("wrap_reads", 256'(rd_cnt - r0), 256'(4));
    check("wrap_beats", 256'(beat_cnt - b0), 256'(16));
    check("wrap_dones", 256'(done_cnt - d0), 256'(1));

    // zero lines
    issue(3, 0);
    check("zero_done_c1", 256'(done), 256'(1));
    check("zero_busy_c1", 256'(busy), 256'(1));
    check("zero_read_c1", 256'(arr_read), 256'(0));
    tick();
    check("zero_done_c2", 256'(done), 256'(0));
    check("zero_busy_c2", 256'(busy), 256'(0));

    // reset during beat 1
    issue(5, 1);
    tick(); tick(); tick();
    check("rstmid_in_beat1", 256'(burst_data), 256'(64'h2222_2222_2222_2222));
    rst_n = 0;
    d0 = done_cnt;
    tick();
    check("rstmid_valid", 256'(burst_valid), 256'(0));
    check("rstmid_data", 256'(burst_data), 256'(0));
    check("rstmid_busy", 256'(busy), 256'(0));
    check("rstmid_read", 256'(arr_read), 256'(0));
    check("rstmid_rindex", 256'(arr_rindex), 256'(0));
    rq.delete();
    bq.delete();
    rst_n = 1;
    tick(); tick(); tick();
    check("rstmid_no_done", 256'(done_cnt - d0), 256'(0));
    issue(2, 2);
    wait_done("after_rst", 40);
    check("after_rst_dones", 256'(done_cnt - d0), 256'(1));

    // start while busy is ignored
    d0 = done_cnt; r0 = rd_cnt;
    issue(3, 2);
    tick(); tick(); tick();
    start_index = 0;
    num_lines = 1;
    start = 1;
    tick();
    start = 0;
    wait_done("busy_start", 40);
    check("busy_start_reads", 256'(rd_cnt - r0), 256'(2));
    check("busy_start_dones", 256'(done_cnt - d0), 256'(1));
    tick(); tick();
    check("busy_start_stays_idle", 256'(busy), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
